// File: rtl/ysyx_24100029_lsu_pkg.sv
// Shared definitions for the load/store stage:
// funct3 access codes, FSM states and AXI response codes.
package ysyx_24100029_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;
  localparam logic [2:0] F3_SW = 3'd2;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AWW,
    S_B,
    S_OUT
  } state_t;

endpackage

// File: rtl/ysyx_24100029_lsu_align.sv
// Byte-lane alignment: load extract/extend, store
// data/strobe generation and misalignment detection.
module ysyx_24100029_lsu_align
  import ysyx_24100029_lsu_pkg::*;
(
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  input  logic [31:0] rs2,
  output logic [31:0] load_data,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        misalign
);

  logic [31:0] sh;
  logic        bad_f3;
  logic        bad_off;

  assign sh    = rdata >> {off, 3'b000};
  assign wdata = rs2 << {off, 3'b000};

  always_comb begin
    load_data = '0;
    case (funct3)
      F3_LB:   load_data = {{24{sh[7]}}, sh[7:0]};
      F3_LH:   load_data = {{16{sh[15]}}, sh[15:0]};
      F3_LW:   load_data = rdata;
      F3_LBU:  load_data = {24'd0, sh[7:0]};
      F3_LHU:  load_data = {16'd0, sh[15:0]};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    wstrb   = 4'b1111;
    bad_off = 1'b0;
    case (funct3[1:0])
      2'd0: wstrb = 4'b0001 << off;
      2'd1: begin
        wstrb   = 4'b0011 << off;
        bad_off = off[0];
      end
      2'd2: bad_off = |off;
      default: bad_off = 1'b0;
    endcase
  end

  // Unsupported encodings fault exactly like a misaligned access.
  assign bad_f3 = is_load
    ? !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU})
    : (funct3 > F3_SW);

  assign misalign = (is_load | is_store) & (bad_f3 | bad_off);

endmodule

// File: rtl/ysyx_24100029_lsu.sv
// Load/store pipeline stage: one AXI4-Lite access at a time,
// registered result handed to write-back via valid/ready.
module ysyx_24100029_lsu
  import ysyx_24100029_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_last,
  output logic              ready_last,
  input  logic [31:0]       pc,
  input  logic [31:0]       inst,
  input  logic [4:0]        rd,
  input  logic              R_wen,
  input  logic [3:0]        csr_wen,
  input  logic [31:0]       csrs,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [2:0]        funct3,
  input  logic [31:0]       EX_result,
  input  logic [31:0]       rs2_value,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic              valid_next,
  input  logic              ready_next,
  output logic [31:0]       pc_next,
  output logic [31:0]       inst_next,
  output logic [31:0]       csrs_next,
  output logic [4:0]        rd_next,
  output logic              R_wen_next,
  output logic [3:0]        csr_wen_next,
  output logic [31:0]       wb_data,
  output logic              mem_err
);

  state_t            state, state_n, disp;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        f3_q;
  logic              aw_done, w_done;
  logic              accept, use_q;
  logic [2:0]        a_f3;
  logic [1:0]        a_off;
  logic [31:0]       load_data, st_wdata;
  logic [3:0]        st_wstrb;
  logic              misalign;

  assign ready_last = (state == S_IDLE)
                    | ((state == S_OUT) & ready_next);
  assign accept = valid_last & ready_last;
  assign araddr = addr_q;
  assign awaddr = addr_q;

  // Outside R the aligner looks at the incoming request.
  assign use_q = (state == S_R);
  assign a_f3  = use_q ? f3_q : funct3;
  assign a_off = use_q ? addr_q[1:0] : EX_result[1:0];

  ysyx_24100029_lsu_align u_align (
    .is_load   (mem_ren),
    .is_store  (mem_wen & ~mem_ren),
    .funct3    (a_f3),
    .off       (a_off),
    .rdata     (rdata),
    .rs2       (rs2_value),
    .load_data (load_data),
    .wdata     (st_wdata),
    .wstrb     (st_wstrb),
    .misalign  (misalign)
  );

  always_comb begin
    disp = S_OUT;
    if (mem_ren)      disp = misalign ? S_OUT : S_AR;
    else if (mem_wen) disp = misalign ? S_OUT : S_AWW;
  end

  always_comb begin
    state_n    = state;
    arvalid    = 1'b0;
    rready     = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    valid_next = 1'b0;
    unique case (state)
      S_IDLE: if (accept) state_n = disp;
      S_AR: begin
        arvalid = 1'b1;
        if (arready) state_n = S_R;
      end
      S_R: begin
        rready = 1'b1;
        if (rvalid) state_n = S_OUT;
      end
      S_AWW: begin
        awvalid = ~aw_done;
        wvalid  = ~w_done;
        if ((aw_done | awready) & (w_done | wready))
          state_n = S_B;
      end
      S_B: begin
        bready = 1'b1;
        if (bvalid) state_n = S_OUT;
      end
      S_OUT: begin
        valid_next = 1'b1;
        if (ready_next) state_n = accept ? disp : S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      addr_q       <= '0;
      f3_q         <= '0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      wdata        <= '0;
      wstrb        <= '0;
      pc_next      <= '0;
      inst_next    <= '0;
      csrs_next    <= '0;
      rd_next      <= '0;
      R_wen_next   <= 1'b0;
      csr_wen_next <= '0;
      wb_data      <= '0;
      mem_err      <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        addr_q       <= EX_result[ADDR_W-1:0];
        f3_q         <= funct3;
        aw_done      <= 1'b0;
        w_done       <= 1'b0;
        wdata        <= st_wdata;
        wstrb        <= st_wstrb;
        pc_next      <= pc;
        inst_next    <= inst;
        csrs_next    <= csrs;
        rd_next      <= rd;
        csr_wen_next <= csr_wen;
        wb_data      <= EX_result;
        mem_err      <= misalign;
        // Stores and faulting accesses never write rd.
        R_wen_next   <= R_wen & ~misalign
                      & (mem_ren | ~mem_wen);
      end
      if (state == S_AWW) begin
        aw_done <= aw_done | awready;
        w_done  <= w_done | wready;
      end
      if (state == S_R && rvalid) begin
        wb_data <= load_data;
        if (rresp != AXI_RESP_OKAY) begin
          mem_err    <= 1'b1;
          R_wen_next <= 1'b0;
        end
      end
      if (state == S_B && bvalid && bresp != AXI_RESP_OKAY)
        mem_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ysyx_24100029_lsu.sv
// Self-checking bench for ysyx_24100029_lsu with an
// inline AXI4-Lite slave and a byte-lane reference model.
module tb_ysyx_24100029_lsu;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid_last, ready_last;
  logic [31:0] pc, inst, csrs, EX_result, rs2_value;
  logic [4:0]  rd;
  logic        R_wen, mem_ren, mem_wen;
  logic [3:0]  csr_wen;
  logic [2:0]  funct3;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready;
  logic        bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;
  logic        valid_next, ready_next;
  logic [31:0] pc_next, inst_next, csrs_next, wb_data;
  logic [4:0]  rd_next;
  logic        R_wen_next, mem_err;
  logic [3:0]  csr_wen_next;

  int checks = 0;
  int errors = 0;

  int          ar_cnt, aw_cnt, w_cnt, b_cnt, stable_bad;
  logic [31:0] cap_araddr, cap_awaddr, cap_wdata, cap_wb, cap_pc;
  logic [3:0]  cap_wstrb;
  logic        cap_err, cap_rwen;
  logic [4:0]  cap_rd;
  logic [31:0] op_pc;
  logic [4:0]  op_rd;
  bit          op_timeout;

  always #5 clock = ~clock;

  ysyx_24100029_lsu dut (
    .clock(clock), .reset(reset),
    .valid_last(valid_last), .ready_last(ready_last),
    .pc(pc), .inst(inst), .rd(rd), .R_wen(R_wen),
    .csr_wen(csr_wen), .csrs(csrs),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .funct3(funct3),
    .EX_result(EX_result), .rs2_value(rs2_value),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
    .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid),
    .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .valid_next(valid_next), .ready_next(ready_next),
    .pc_next(pc_next), .inst_next(inst_next),
    .csrs_next(csrs_next), .rd_next(rd_next),
    .R_wen_next(R_wen_next), .csr_wen_next(csr_wen_next),
    .wb_data(wb_data), .mem_err(mem_err)
  );

  // Reference model: byte-lane view of the access rules.
  function automatic int acc_size(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit m_legal(input bit ld,
                                 input logic [2:0] f3,
                                 input logic [1:0] off);
    bit ok;
    if (ld) ok = (f3 == 0 || f3 == 1 || f3 == 2 ||
                  f3 == 4 || f3 == 5);
    else    ok = (f3 <= 2);
    return ok && ((int'(off) % acc_size(f3)) == 0);
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3,
                                         input logic [1:0] off,
                                         input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[8*off +: 8];
    h = off[1] ? d[31:16] : d[15:0];
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd4:    return {24'd0, b};
      3'd5:    return {16'd0, h};
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3,
                                        input logic [1:0] off);
    logic [3:0] s;
    for (int i = 0; i < 4; i++)
      s[i] = (i >= int'(off)) && (i < int'(off) + acc_size(f3));
    return s;
  endfunction

  task automatic idle_inputs();
    valid_last = 0; ready_next = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
  endtask

  // Issue one op and act as AXI slave until write-back consumes it.
  task automatic do_op(input logic ren, input logic wen,
                       input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] rs2,
                       input logic [31:0] rd_data,
                       input logic [1:0] rr, input logic [1:0] br,
                       input int ar_d, input int r_d, input int aw_d,
                       input int w_d, input int b_d, input int hold,
                       input logic rwen);
    int arw, rw, aww, ww, bw, h;
    bit done;
    arw = 0; rw = 0; aww = 0; ww = 0; bw = 0; h = 0; done = 0;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; stable_bad = 0;
    op_timeout = 0;
    @(negedge clock);
    op_pc = $urandom; op_rd = 5'($urandom);
    pc = op_pc; inst = $urandom; rd = op_rd; R_wen = rwen;
    csr_wen = 4'($urandom); csrs = $urandom;
    mem_ren = ren; mem_wen = wen; funct3 = f3;
    EX_result = addr; rs2_value = rs2;
    valid_last = 1; ready_next = 0;
    #1;
    if (!ready_last) stable_bad++;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      @(negedge clock);
      idle_inputs();
      #1;
      if (arvalid) begin
        cap_araddr = araddr;
        if (arw >= ar_d) begin arready = 1; ar_cnt++; end
        arw++;
      end
      if (rready && ar_cnt > 0) begin
        if (rw >= r_d) begin
          rvalid = 1; rdata = rd_data; rresp = rr;
        end
        rw++;
      end
      if (awvalid) begin
        cap_awaddr = awaddr;
        if (aww >= aw_d) begin awready = 1; aw_cnt++; end
        aww++;
      end
      if (wvalid) begin
        cap_wdata = wdata; cap_wstrb = wstrb;
        if (ww >= w_d) begin wready = 1; w_cnt++; end
        ww++;
      end
      if (bready) begin
        if (bw >= b_d) begin
          bvalid = 1; bresp = br; b_cnt++;
        end
        bw++;
      end
      if (valid_next) begin
        if (h == 0) begin
          cap_wb = wb_data; cap_err = mem_err;
          cap_rwen = R_wen_next; cap_pc = pc_next;
          cap_rd = rd_next;
        end else if (wb_data !== cap_wb || mem_err !== cap_err ||
                     R_wen_next !== cap_rwen ||
                     pc_next !== cap_pc) begin
          stable_bad++;
        end
        if (ready_last) stable_bad++;
        if (h >= hold) begin ready_next = 1; done = 1; end
        h++;
      end
    end
    @(negedge clock);
    idle_inputs();
    if (!done) op_timeout = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    pc = 0; inst = 0; rd = 0; R_wen = 0; csr_wen = 0; csrs = 0;
    mem_ren = 0; mem_wen = 0; funct3 = 0; EX_result = 0;
    rs2_value = 0;
    reset = 1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({arvalid, rready, awvalid, wvalid, bready, valid_next}
        !== 6'b0) begin
      errors++;
      $display("FAIL reset_valids got %b exp 000000",
               {arvalid, rready, awvalid, wvalid, bready, valid_next});
    end
    checks++;
    if (ready_last !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_last got %b exp 1", ready_last);
    end
    checks++;
    if ({araddr, awaddr, wdata, wstrb} !== 100'd0) begin
      errors++;
      $display("FAIL reset_bus got %h/%h/%h/%h exp 0",
               araddr, awaddr, wdata, wstrb);
    end
    checks++;
    if ({pc_next, inst_next, csrs_next, rd_next, R_wen_next,
         csr_wen_next, wb_data, mem_err} !== 139'd0) begin
      errors++;
      $display("FAIL reset_stage_regs got %h %h %h exp 0",
               pc_next, wb_data, mem_err);
    end
    reset = 0;
  endtask

  task automatic test_alu_stream();
    logic [31:0] pcs[4];
    int bus_seen;
    bus_seen = 0;
    @(negedge clock);
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) begin
        checks++;
        if (valid_next !== 1'b1 || wb_data !== 32'h1234 ||
            pc_next !== pcs[k-1] || mem_err !== 1'b0) begin
          errors++;
          $display("FAIL alu_stream[%0d] got v=%b wb=%h pc=%h exp v=1 wb=00001234 pc=%h",
                   k, valid_next, wb_data, pc_next, pcs[k-1]);
        end
      end
      if (k < 4) begin
        pcs[k] = $urandom;
        pc = pcs[k]; R_wen = 1; mem_ren = 0; mem_wen = 0;
        funct3 = 3'($urandom); EX_result = 32'h1234;
        valid_last = 1; ready_next = 1;
      end else begin
        valid_last = 0;
      end
      #1;
      if (arvalid || awvalid || wvalid) bus_seen++;
      if (k < 4 && !ready_last) bus_seen++;
      @(negedge clock);
    end
    checks++;
    if (valid_next !== 1'b0) begin
      errors++;
      $display("FAIL alu_drain got %b exp 0", valid_next);
    end
    checks++;
    if (bus_seen != 0) begin
      errors++;
      $display("FAIL alu_no_bus got %0d exp 0", bus_seen);
    end
    idle_inputs();
  endtask

  task automatic test_load_directed();
    do_op(1, 0, 3'd0, 32'h80000003, 0, 32'h80FF7F00, 0, 0,
          1, 1, 0, 0, 0, 0, 1);
    checks++;
    if (cap_araddr !== 32'h80000003 || ar_cnt != 1) begin
      errors++;
      $display("FAIL lb_ar got %h n=%0d exp 80000003 n=1",
               cap_araddr, ar_cnt);
    end
    checks++;
    if (op_timeout || cap_wb !== 32'hFFFFFF80 || cap_err !== 0 ||
        cap_rwen !== 1) begin
      errors++;
      $display("FAIL lb_data got %h err=%b wen=%b exp ffffff80 err=0 wen=1",
               cap_wb, cap_err, cap_rwen);
    end
    do_op(1, 0, 3'd4, 32'h80000003, 0, 32'h80FF7F00, 0, 0,
          0, 2, 0, 0, 0, 0, 1);
    checks++;
    if (op_timeout || cap_wb !== 32'h00000080) begin
      errors++;
      $display("FAIL lbu_data got %h exp 00000080", cap_wb);
    end
  endtask

  task automatic test_store_sh();
    do_op(0, 1, 3'd1, 32'h80000002, 32'h0000BEEF, 0, 0, 0,
          0, 0, 3, 0, 0, 0, 1);
    checks++;
    if (cap_wdata !== 32'hBEEF0000 || cap_wstrb !== 4'b1100) begin
      errors++;
      $display("FAIL sh_w got %h/%b exp beef0000/1100",
               cap_wdata, cap_wstrb);
    end
    checks++;
    if (cap_awaddr !== 32'h80000002 || aw_cnt != 1 ||
        w_cnt != 1 || b_cnt != 1) begin
      errors++;
      $display("FAIL sh_hs got %h aw=%0d w=%0d b=%0d exp 80000002 1 1 1",
               cap_awaddr, aw_cnt, w_cnt, b_cnt);
    end
    checks++;
    if (op_timeout || cap_rwen !== 0 || cap_err !== 0) begin
      errors++;
      $display("FAIL sh_wb got wen=%b err=%b exp 0 0",
               cap_rwen, cap_err);
    end
  endtask

  task automatic test_misalign();
    do_op(1, 0, 3'd2, 32'h80000001, 0, 32'h11223344, 0, 0,
          0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (op_timeout || ar_cnt != 0 || cap_err !== 1 ||
        cap_rwen !== 0) begin
      errors++;
      $display("FAIL lw_misalign got ar=%0d err=%b wen=%b exp 0 1 0",
               ar_cnt, cap_err, cap_rwen);
    end
    do_op(0, 1, 3'd1, 32'h80000003, 32'h1234, 0, 0, 0,
          0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (op_timeout || aw_cnt != 0 || w_cnt != 0 || cap_err !== 1) begin
      errors++;
      $display("FAIL sh_misalign got aw=%0d w=%0d err=%b exp 0 0 1",
               aw_cnt, w_cnt, cap_err);
    end
    do_op(1, 0, 3'd6, 32'h80000000, 0, 0, 0, 0,
          0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (op_timeout || ar_cnt != 0 || cap_err !== 1) begin
      errors++;
      $display("FAIL ld_f3_unsup got ar=%0d err=%b exp 0 1",
               ar_cnt, cap_err);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b;
    do_op(1, 0, 3'd2, 32'h80000010, 0, 32'hCAFEF00D, 0, 0,
          1, 2, 0, 0, 0, 5, 1);
    checks++;
    if (op_timeout || stable_bad != 0 || cap_wb !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL bp_load got wb=%h unstable=%0d exp cafef00d 0",
               cap_wb, stable_bad);
    end
    a = $urandom; b = $urandom;
    @(negedge clock);
    mem_ren = 0; mem_wen = 0; EX_result = a; R_wen = 1;
    valid_last = 1; ready_next = 0;
    for (int h = 0; h < 5; h++) begin
      @(negedge clock);
      EX_result = b; valid_last = 1; ready_next = 0;
      #1;
      checks++;
      if (valid_next !== 1 || wb_data !== a || ready_last !== 0) begin
        errors++;
        $display("FAIL bp_hold[%0d] got v=%b wb=%h rl=%b exp 1 %h 0",
                 h, valid_next, wb_data, ready_last, a);
      end
    end
    @(negedge clock);
    ready_next = 1;
    #1;
    checks++;
    if (ready_last !== 1) begin
      errors++;
      $display("FAIL bp_release got rl=%b exp 1", ready_last);
    end
    @(negedge clock);
    valid_last = 0;
    checks++;
    if (valid_next !== 1 || wb_data !== b) begin
      errors++;
      $display("FAIL bp_next got v=%b wb=%h exp 1 %h",
               valid_next, wb_data, b);
    end
    @(negedge clock);
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    bit in_r;
    in_r = 0;
    @(negedge clock);
    mem_ren = 1; mem_wen = 0; funct3 = 3'd2;
    EX_result = 32'h80000100; valid_last = 1;
    for (int c = 0; c < 20 && !in_r; c++) begin
      @(negedge clock);
      valid_last = 0;
      #1;
      arready = arvalid;
      if (rready) in_r = 1;
    end
    checks++;
    if (!in_r) begin
      errors++;
      $display("FAIL rst_mid_reach_r got 0 exp 1");
    end
    arready = 0;
    reset = 1;
    @(negedge clock);
    reset = 0;
    checks++;
    if ({arvalid, rready, awvalid, wvalid, bready, valid_next}
        !== 6'b0 || ready_last !== 1) begin
      errors++;
      $display("FAIL rst_mid got valids=%b rl=%b exp 000000 1",
               {arvalid, rready, awvalid, wvalid, bready, valid_next},
               ready_last);
    end
    @(negedge clock);
    checks++;
    if (rready !== 0 || valid_next !== 0 || ready_last !== 1) begin
      errors++;
      $display("FAIL rst_mid_idle got rr=%b v=%b rl=%b exp 0 0 1",
               rready, valid_next, ready_last);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    logic        ren, wen, ok, exp_err;
    logic [2:0]  f3;
    logic [31:0] addr, rs2, d;
    logic [1:0]  rr, br;
    int          kind;
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 2);
      ren = (kind == 1); wen = (kind == 2);
      if ($urandom_range(0, 7) == 0) begin ren = 1; wen = 1; end
      f3 = 3'($urandom);
      addr = $urandom; rs2 = $urandom; d = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      rr = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      br = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      do_op(ren, wen, f3, addr, rs2, d, rr, br,
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 2), 1'b1);
      checks++;
      if (op_timeout || stable_bad != 0 || cap_pc !== op_pc ||
          cap_rd !== op_rd) begin
        errors++;
        $display("FAIL rnd_out[%0d] to=%b unst=%0d pc=%h/%h rd=%0d/%0d",
                 n, op_timeout, stable_bad, cap_pc, op_pc, cap_rd, op_rd);
      end
      if (ren) begin
        ok = m_legal(1, f3, addr[1:0]);
        exp_err = !ok || (rr != 0);
        checks++;
        if (ar_cnt != int'(ok) || (ok && cap_araddr !== addr)) begin
          errors++;
          $display("FAIL rnd_ar[%0d] got n=%0d a=%h exp n=%0d a=%h",
                   n, ar_cnt, cap_araddr, ok, addr);
        end
        checks++;
        if (cap_err !== exp_err || cap_rwen !== !exp_err ||
            (!exp_err && cap_wb !== m_load(f3, addr[1:0], d))) begin
          errors++;
          $display("FAIL rnd_load[%0d] got wb=%h err=%b wen=%b exp wb=%h err=%b",
                   n, cap_wb, cap_err, cap_rwen,
                   m_load(f3, addr[1:0], d), exp_err);
        end
      end else if (wen) begin
        ok = m_legal(0, f3, addr[1:0]);
        exp_err = !ok || (br != 0);
        checks++;
        if (aw_cnt != int'(ok) || w_cnt != int'(ok) ||
            b_cnt != int'(ok)) begin
          errors++;
          $display("FAIL rnd_st_hs[%0d] got %0d %0d %0d exp %0d",
                   n, aw_cnt, w_cnt, b_cnt, ok);
        end
        checks++;
        if (ok && (cap_awaddr !== addr ||
                   cap_wdata !== (rs2 << (8 * addr[1:0])) ||
                   cap_wstrb !== m_strb(f3, addr[1:0]))) begin
          errors++;
          $display("FAIL rnd_st_w[%0d] got %h %h %b exp %h %h %b",
                   n, cap_awaddr, cap_wdata, cap_wstrb, addr,
                   rs2 << (8 * addr[1:0]), m_strb(f3, addr[1:0]));
        end
        checks++;
        if (cap_err !== exp_err || cap_rwen !== 0) begin
          errors++;
          $display("FAIL rnd_st_wb[%0d] got err=%b wen=%b exp %b 0",
                   n, cap_err, cap_rwen, exp_err);
        end
      end else begin
        checks++;
        if (cap_wb !== addr || cap_err !== 0 || cap_rwen !== 1 ||
            ar_cnt != 0 || aw_cnt != 0) begin
          errors++;
          $display("FAIL rnd_alu[%0d] got wb=%h err=%b wen=%b exp %h 0 1",
                   n, cap_wb, cap_err, cap_rwen, addr);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_stream();
    test_load_directed();
    test_store_sh();
    test_misalign();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
